// File: rtl/txt_pkg.sv
// Shared types and helpers for the text-mode rasteriser: FSM state codes,
// character attributes and the interleaved text-page row mapping.
package txt_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE       = 3'd0;
  localparam state_t FETCH_TXT  = 3'd1;
  localparam state_t WAIT_TXT   = 3'd2;
  localparam state_t WAIT_GLYPH = 3'd3;
  localparam state_t EMIT       = 3'd4;
  localparam state_t DONE       = 3'd5;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    INVERSE = 2'd1,
    FLASH   = 2'd2
  } attr_e;

  localparam logic [15:0] TXT_ROW_STRIDE   = 16'h0080;
  localparam logic [15:0] TXT_THIRD_STRIDE = 16'h0028;

  // Rows within a group of eight are 'h80 apart; each group of eight is 'h28 further on.
  function automatic logic [15:0] txt_row_base(input logic [15:0] r);
    return ({13'd0, r[2:0]} * TXT_ROW_STRIDE) + ((r >> 3) * TXT_THIRD_STRIDE);
  endfunction

  function automatic attr_e attr_of(input logic [7:0] code);
    attr_e a;
    if (code[7]) begin
      a = NORMAL;
    end else if (code[6]) begin
      a = FLASH;
    end else begin
      a = INVERSE;
    end
    return a;
  endfunction

endpackage

// File: rtl/txt_raster_if.sv
// Bus bundle of the rasteriser: frame control, text RAM, character ROM and
// vram write port. The rasteriser is the master.
interface txt_raster_if #(
  parameter int CROM_W = 11,
  parameter int VADR_W = 16,
  parameter int PIX_W  = 24
);
  logic              start;
  logic              busy;
  logic              done;
  logic [15:0]       txt_adr;
  logic [7:0]        txt_q;
  logic [CROM_W-1:0] crom_adr;
  logic [7:0]        crom_q;
  logic              vram_we;
  logic              vram_ready;
  logic [VADR_W-1:0] vram_wadr;
  logic [PIX_W-1:0]  vram_d;

  modport master (
    input  start, txt_q, crom_q, vram_ready,
    output busy, done, txt_adr, crom_adr, vram_we, vram_wadr, vram_d
  );

  modport slave (
    output start, txt_q, crom_q, vram_ready,
    input  busy, done, txt_adr, crom_adr, vram_we, vram_wadr, vram_d
  );
endinterface

// File: rtl/txt_addr_gen.sv
// Column / scanline counters of the rasteriser and the text RAM and
// character ROM addresses derived from them.
module txt_addr_gen
  import txt_pkg::*;
#(
  parameter int          COLS     = 40,
  parameter int          ROWS     = 24,
  parameter int          GLYPH_H  = 8,
  parameter logic [15:0] TXT_BASE = 16'h0400,
  localparam int         GH_W     = $clog2(GLYPH_H),
  localparam int         CROM_W   = 8 + GH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  input  logic [7:0]        code,
  output logic [15:0]       txt_adr,
  output logic [CROM_W-1:0] crom_adr,
  output logic              last_char
);

  localparam int C_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int Y_W = $clog2(ROWS * GLYPH_H);
  localparam logic [C_W-1:0] COL_LAST = C_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(ROWS * GLYPH_H - 1);

  logic [C_W-1:0] col_q, col_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [15:0]    row_s;

  // Advance column-major within a scanline; wrap to the top after the last character.
  always_comb begin
    col_d = col_q;
    y_d   = y_q;
    if (clr) begin
      col_d = '0;
      y_d   = '0;
    end else if (adv) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        y_d   = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
      end else begin
        col_d = col_q + C_W'(1);
      end
    end else begin
      col_d = col_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      y_q   <= '0;
    end else begin
      col_q <= col_d;
      y_q   <= y_d;
    end
  end

  assign row_s     = 16'(y_q >> GH_W);
  assign txt_adr   = TXT_BASE + txt_row_base(row_s) + 16'(col_q);
  assign crom_adr  = {code, y_q[GH_W-1:0]};
  assign last_char = (col_q == COL_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/txt_raster.sv
// Text-mode rasteriser: fetches each character and glyph row of the text page
// and writes one pixel per accepted cycle into vram in raster order.
module txt_raster
  import txt_pkg::*;
#(
  parameter int               COLS         = 40,
  parameter int               ROWS         = 24,
  parameter int               GLYPH_W      = 7,
  parameter int               GLYPH_H      = 8,
  parameter int               PIX_W        = 24,
  parameter int               VADR_W       = 16,
  parameter logic [15:0]      TXT_BASE     = 16'h0400,
  parameter logic [PIX_W-1:0] FG           = PIX_W'(24'hffffff),
  parameter logic [PIX_W-1:0] BG           = PIX_W'(24'h000000),
  parameter int               FLASH_FRAMES = 16
) (
  input logic         clk,
  input logic         reset,
  txt_raster_if.master bus
);

  localparam int GH_W   = $clog2(GLYPH_H);
  localparam int CROM_W = 8 + GH_W;
  localparam int I_W    = $clog2(GLYPH_W);
  localparam int FC_W   = $clog2(FLASH_FRAMES + 1);
  localparam logic [I_W-1:0]  PIX_LAST   = I_W'(GLYPH_W - 1);
  localparam logic [FC_W-1:0] FLASH_LAST = FC_W'(FLASH_FRAMES - 1);

  state_t              state_q, state_d;
  logic [7:0]          code_q, code_d;
  logic [7:0]          glyph_q, glyph_d;
  logic                inv_q, inv_d;
  logic [I_W-1:0]      pix_q, pix_d;
  logic                we_q, we_d;
  logic [VADR_W-1:0]   wadr_q, wadr_d;
  logic [PIX_W-1:0]    vd_q, vd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FC_W-1:0]     fcnt_q, fcnt_d;
  logic                phase_q, phase_d;

  logic                adv_s, clr_s, last_char_s, inv_s;
  logic [7:0]          code_s;
  logic [15:0]         txt_adr_s;
  logic [CROM_W-1:0]   crom_adr_s;
  attr_e               attr_s;

  function automatic logic [PIX_W-1:0] pixel(input logic [7:0] glyph,
                                             input logic [I_W-1:0] i,
                                             input logic inv);
    logic lit;
    lit = glyph[3'(GLYPH_W - 1) - 3'(i)];
    return (lit ^ inv) ? FG : BG;
  endfunction

  // The ROM address must carry the code during the very cycle txt_q arrives.
  assign code_s = (state_q == WAIT_TXT) ? bus.txt_q : code_q;
  assign attr_s = attr_of(code_q);
  assign inv_s  = (attr_s == INVERSE) || ((attr_s == FLASH) && phase_q);

  txt_addr_gen #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .GLYPH_H  (GLYPH_H),
    .TXT_BASE (TXT_BASE)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_s),
    .adv       (adv_s),
    .code      (code_s),
    .txt_adr   (txt_adr_s),
    .crom_adr  (crom_adr_s),
    .last_char (last_char_s)
  );

  // Frame sequencer; the next pixel is preloaded on each accept so outputs stay registered.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    glyph_d = glyph_q;
    inv_d   = inv_q;
    pix_d   = pix_q;
    we_d    = we_q;
    wadr_d  = wadr_q;
    vd_d    = vd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    adv_s   = 1'b0;
    clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH_TXT;
          clr_s   = 1'b1;
          wadr_d  = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH_TXT: state_d = WAIT_TXT;
      WAIT_TXT: begin
        code_d  = bus.txt_q;
        state_d = WAIT_GLYPH;
      end
      WAIT_GLYPH: begin
        glyph_d = bus.crom_q;
        inv_d   = inv_s;
        pix_d   = '0;
        vd_d    = pixel(bus.crom_q, '0, inv_s);
        we_d    = 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        if (bus.vram_ready) begin
          wadr_d = wadr_q + VADR_W'(1);
          if (pix_q == PIX_LAST) begin
            we_d  = 1'b0;
            adv_s = 1'b1;
            if (last_char_s) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH_TXT;
            end
          end else begin
            pix_d = pix_q + I_W'(1);
            vd_d  = pixel(glyph_q, pix_q + I_W'(1), inv_q);
          end
        end else begin
          state_d = EMIT;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (fcnt_q == FLASH_LAST) begin
          fcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          fcnt_d = fcnt_q + FC_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      glyph_q <= '0;
      inv_q   <= 1'b0;
      pix_q   <= '0;
      we_q    <= 1'b0;
      wadr_q  <= '0;
      vd_q    <= BG;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      glyph_q <= glyph_d;
      inv_q   <= inv_d;
      pix_q   <= pix_d;
      we_q    <= we_d;
      wadr_q  <= wadr_d;
      vd_q    <= vd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.txt_adr   = txt_adr_s;
  assign bus.crom_adr  = crom_adr_s;
  assign bus.vram_we   = we_q;
  assign bus.vram_wadr = wadr_q;
  assign bus.vram_d    = vd_q;

endmodule

// File: doc/txt_raster.md
# txt_raster

Parametrised text-mode rasteriser: walks the interleaved Apple-style text page, fetches each character code and its glyph row, and writes one pixel per accepted cycle into the frame buffer in raster order. It sits between text RAM, the character ROM and the vram write port. Compared with the current renderer it adds:

- frame start/done control;
- write back-pressure;
- inverse and flash attributes;
- configurable geometry.

## Interface
- `COLS`, 40, characters per text row
- `ROWS`, 24, text rows (multiple of 8)
- `GLYPH_W`, 7, pixels per glyph row
- `GLYPH_H`, 8, glyph rows (power of two)
- `PIX_W`, 24, pixel width
- `VADR_W`, 16, vram address width; must satisfy COLS·GLYPH_W·ROWS·GLYPH_H ≤ 2^VADR_W
- `TXT_BASE`, 16'h400, text page base
- `FG`, 24'hffffff, foreground pixel
- `BG`, 24'h000000, background pixel
- `FLASH_FRAMES`, 16, frames per flash phase
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  pulse: render one frame
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse after last pixel accepted
- `txt_adr`  out  16  text RAM address
- `txt_q`  in  8  character code, valid 1 cycle after `txt_adr`
- `crom_adr`  out  8+$clog2(GLYPH_H)  {code, glyph row}
- `crom_q`  in  8  glyph bits, valid 1 cycle after `crom_adr`
- `vram_we`  out  1  write valid
- `vram_ready`  in  1  write accepted when `vram_we` && `vram_ready`
- `vram_wadr`  out  VADR_W  pixel address
- `vram_d`  out  PIX_W  pixel

## Operation
- **Frame start:** `start` while IDLE latches a frame. `start` while busy is ignored.
- **Scan order:** scanline `y` = 0..ROWS·GLYPH_H−1. Within each scanline, column `c` = 0..COLS−1, then pixel `i` = 0..GLYPH_W−1.
- **Addresses:**
  - text row r = y / GLYPH_H.
  - `txt_adr` = TXT_BASE + 'h80·(r%8) + 'h28·(r/8) + c. Arithmetic is 16-bit.
  - `crom_adr` = {code, y%GLYPH_H}.
- **Pixel address:** `vram_wadr` = y·COLS·GLYPH_W + c·GLYPH_W + i, strictly sequential from 0.
- **Pixel source:** pixel i uses `crom_q[GLYPH_W-1-i]`.
- **Attributes:**
  - code[7:6] = 00: inverse.
  - code[7:6] = 01: flash, inverted while flash phase = 1.
  - code[7] = 1: normal.
  - Lit and non-inverted → FG. Otherwise BG. Inversion swaps the two.
- **Flash counter:** counts completed frames. The phase toggles when it reaches FLASH_FRAMES, and the counter then clears. The counter and phase survive between frames and are cleared only by reset.
- **FSM states:**
  - IDLE → FETCH_TXT on `start`.
  - FETCH_TXT: drive `txt_adr` → WAIT_TXT.
  - WAIT_TXT: capture `txt_q`, drive `crom_adr` → WAIT_GLYPH.
  - WAIT_GLYPH: capture `crom_q` and attribute → EMIT.
  - EMIT: assert `vram_we`. Advance `i` only on accept.
  - After pixel GLYPH_W−1 is accepted:
    - next column → FETCH_TXT;
    - end of scanline → c=0, y+1, FETCH_TXT;
    - last pixel of frame → DONE.
  - DONE: pulse `done`, bump the flash counter → IDLE.
- **Back-pressure:** while `vram_ready`=0, `vram_wadr`, `vram_d` and `vram_we` are held stable.
- **Reset:** asynchronous reset at any point aborts the frame → IDLE.
  - Reset values: `busy`, `done`, `vram_we` = 0; `vram_wadr` = 0; `vram_d` = BG; `txt_adr` = TXT_BASE; `crom_adr` = 0.
  - Flash phase 0, counter 0.

## Timing
- `busy` rises the cycle after `start` and falls with `done`.
- First `vram_we` occurs 4 cycles after `start` (IDLE, FETCH_TXT, WAIT_TXT, WAIT_GLYPH).
- Per character: 3 fetch cycles plus GLYPH_W accepted writes.
- Frame with `vram_ready` tied high: 1 + COLS·ROWS·GLYPH_H·(GLYPH_W+3) + 1 cycles. Defaults: 76,802 cycles.
- `vram_we` is low during fetch cycles. No write is issued twice; no address is skipped.
- `done` asserts the cycle after the final accept.
- `start` coincident with `done` is ignored. A new frame needs `start` while IDLE.

## Structure
- `txt_pkg` holds:
  - FSM state enum (IDLE, FETCH_TXT, WAIT_TXT, WAIT_GLYPH, EMIT, DONE);
  - attribute enum (NORMAL, INVERSE, FLASH);
  - interleave constants 'h80/'h28;
  - function `txt_row_base(r)`.
- One sub-module, `txt_addr_gen`: owns the c/y counters and produces `txt_adr`/`crom_adr` under FSM advance strobes.

## Test plan
- **Reset values:** reset asserted mid-EMIT at pixel 100 → all outputs at reset values next edge. New `start` restarts at `vram_wadr` 0.
- **Interleave mapping:** text RAM holds code 'hC1 only at 'h4A8 (row 9, col 0). Defaults, ready=1 → scanlines 72–79 pixels 0–6 follow ROM glyph 'hC1; all other pixels BG; `done` at cycle 76,802.
- **Inverse:** code 'h01 with a blank glyph everywhere → every pixel FG. Code 'h81 → every pixel BG.
- **Flash:** code 'h41, FLASH_FRAMES=2 → frames 0–1 normal, frames 2–3 inverted, frame 4 normal.
- **Back-pressure:** `vram_ready` random 30% low → address sequence 0..53759 exactly once, in order. Data matches the ready=1 run; `vram_d` held while stalled.
- **Start handling:** `start` pulsed while busy and on the `done` cycle → ignored, exactly one frame rendered. Non-default geometry COLS=80, GLYPH_W=7, VADR_W=17 → last `vram_wadr` 107519.
